// File: rtl/key_pkg.sv
// Shared timing defaults (50 MHz clock) and counter sizing for the front-panel key debouncer.
package key_pkg;

  localparam int KEY_WIPE_20MS    = 1000000;
  localparam int KEY_LONG_1S      = 50000000;
  localparam int KEY_REPEAT_200MS = 10000000;

  // Width of a counter that must hold 0 .. depth-1; never narrower than one bit.
  function automatic int cnt_width(input int depth);
    return (depth <= 32'sd2) ? 32'sd1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: two-flop synchroniser, stability filter, hold timer and pulse outputs.
// Optional auto-repeat counter is built only when KEY_REPEAT_EN is defined.
module key_debounce_chan
  import key_pkg::*;
#(
  parameter int WIPE_TIME   = KEY_WIPE_20MS,
  parameter int LONG_TIME   = KEY_LONG_1S,
  parameter int REPEAT_TIME = KEY_REPEAT_200MS,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int WW = cnt_width(WIPE_TIME);
  localparam int LW = cnt_width(LONG_TIME);
  localparam logic [WW-1:0] WIPE_MAX = WW'(WIPE_TIME - 1);
  localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TIME - 1);
  localparam logic [LW-1:0] LONG_PRE = LW'(LONG_TIME - 2);

  logic          s1_q, s2_q, s3_q;
  logic [WW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] hold_q, hold_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          n_s, stable_s, accept_s;

  // Stability filter, accept decision and hold timer next-state.
  always_comb begin
    n_s      = key_i ^ ACTIVE_LOW;
    stable_s = (s2_q == s3_q);
    if (!stable_s) begin
      cnt_d = '0;
    end else if (cnt_q != WIPE_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    // A saturated count only proves stability while s2 still equals its history.
    accept_s  = stable_s && (cnt_q == WIPE_MAX) && (s2_q != level_q);
    level_d   = accept_s ? s2_q : level_q;
    press_d   = accept_s & s2_q;
    release_d = accept_s & ~s2_q;
    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != LONG_MAX) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end
    long_d = level_q && (hold_q == LONG_PRE);
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      s1_q      <= n_s;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

`ifdef KEY_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_TIME);
  localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_TIME - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          repeat_q, repeat_d;
  logic          armed_s;

  // Repeat timer runs only once the hold timer has saturated (key_long already fired).
  always_comb begin
    armed_s = level_q && (hold_q == LONG_MAX);
    if (!armed_s) begin
      rep_d = '0;
    end else if (rep_q == REP_MAX) begin
      rep_d = '0;
    end else begin
      rep_d = rep_q + 1'b1;
    end
    repeat_d = armed_s && (rep_q == REP_MAX);
  end

  // Repeat state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_q    <= '0;
      repeat_q <= 1'b0;
    end else begin
      rep_q    <= rep_d;
      repeat_q <= repeat_d;
    end
  end

  assign repeat_o = repeat_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel key debouncer for the clock-calendar front panel; channels are fully independent.
// Define KEY_REPEAT_EN to enable the per-channel auto-repeat pulse.
module multi_key_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int WIPE_TIME   = KEY_WIPE_20MS,
  parameter int LONG_TIME   = KEY_LONG_1S,
  parameter int REPEAT_TIME = KEY_REPEAT_200MS,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_debounce_chan #(
      .WIPE_TIME  (WIPE_TIME),
      .LONG_TIME  (LONG_TIME),
      .REPEAT_TIME(REPEAT_TIME),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .key_i    (key_in[i]),
      .level_o  (key_level[i]),
      .press_o  (key_press[i]),
      .release_o(key_release[i]),
      .long_o   (key_long[i]),
      .repeat_o (key_repeat[i])
    );
  end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Scoreboard bench for multi_key_debounce: stimulus queues expected pulses, a monitor matches them.
module tb_multi_key_debounce;

  localparam int N    = 4;
  localparam int WIPE = 8;
  localparam int LONG = 40;
  localparam int REP  = 16;
  localparam int LAT  = WIPE + 3;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  typedef struct {
    int cyc;
    int kind;
    int ch;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_level, key_press, key_release, key_long, key_repeat;

  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  int    mon_idx;
  int    c;
  ev_t   exp_q[$];
  string kname[4] = '{"press", "release", "long", "repeat"};

  multi_key_debounce #(
    .N_KEYS     (N),
    .WIPE_TIME  (WIPE),
    .LONG_TIME  (LONG),
    .REPEAT_TIME(REP),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input int kind, input int ch);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.ch   = ch;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic pulse_bit(input int k, input int ch);
    case (k)
      K_PRESS: return key_press[ch];
      K_REL:   return key_release[ch];
      K_LONG:  return key_long[ch];
      default: return key_repeat[ch];
    endcase
  endfunction

  // Monitor: every asserted pulse must match a queued expectation for this exact cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (pulse_bit(k, ch) === 1'b1) begin
          mon_idx = -1;
          for (int j = 0; j < exp_q.size(); j++) begin
            if (mon_idx < 0 && exp_q[j].cyc == cyc && exp_q[j].kind == k && exp_q[j].ch == ch)
              mon_idx = j;
          end
          n_tests++;
          if (mon_idx >= 0) begin
            exp_q.delete(mon_idx);
          end else begin
            n_fail++;
            $display("FAIL pulse_%s ch%0d: asserted at cycle %0d, no pulse expected then",
                     kname[k], ch, cyc);
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    key_in = '1;
    step(3);
    chk("reset_outputs", {12'd0, key_level, key_press, key_release, key_long, key_repeat}, 32'd0);
    rst = 1'b0;
    step(15);
    chk("idle_level", key_level, 32'd0);

    // Test 1: clean press on key 0, latency boundary.
    c = cyc;
    key_in[0] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 0);
    step(LAT - 1);
    chk("t1_level_before_latency", key_level, 32'd0);
    step(1);
    chk("t1_level_at_latency", key_level, 32'h1);
    step(2);
    c = cyc;
    key_in[0] = 1'b1;
    expect_ev(c + LAT, K_REL, 0);
    step(LAT);
    chk("t1_level_released", key_level, 32'd0);
    step(5);

    // Test 2: bounce on key 1 every 3 cycles, then settle pressed.
    for (int i = 0; i < 10; i++) begin
      key_in[1] = ~key_in[1];
      step(3);
    end
    chk("t2_no_level_during_bounce", key_level, 32'd0);
    c = cyc;
    key_in[1] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 1);
    step(LAT);
    chk("t2_level_after_settle", key_level, 32'h2);
    step(4);
    c = cyc;
    key_in[1] = 1'b1;
    expect_ev(c + LAT, K_REL, 1);
    step(LAT + 5);

    // Test 3: long press on key 2 held 60 cycles.
    c = cyc;
    key_in[2] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 2);
    expect_ev(c + LAT + LONG - 1, K_LONG, 2);
`ifdef KEY_REPEAT_EN
    expect_ev(c + LAT + LONG - 1 + REP, K_REP, 2);
`endif
    step(60);
    chk("t3_level_held", key_level, 32'h4);
    c = cyc;
    key_in[2] = 1'b1;
    expect_ev(c + LAT, K_REL, 2);
    step(LAT + 3);
    chk("t3_level_released", key_level, 32'd0);

    // Test 4: keys 0 and 3 pressed on the same edge.
    c = cyc;
    key_in = 4'b0110;
    expect_ev(c + LAT, K_PRESS, 0);
    expect_ev(c + LAT, K_PRESS, 3);
    step(LAT);
    chk("t4_level_both", key_level, 32'h9);
    step(4);
    c = cyc;
    key_in = 4'b1111;
    expect_ev(c + LAT, K_REL, 0);
    expect_ev(c + LAT, K_REL, 3);
    step(LAT + 3);

    // Test 5: reset in the middle of a hold, key kept pressed.
    c = cyc;
    key_in[0] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 0);
    step(LAT + 20);
    chk("t5_level_before_reset", key_level, 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_outputs_in_reset", {12'd0, key_level, key_press, key_release, key_long, key_repeat}, 32'd0);
    step(2);
    rst = 1'b0;
    c = cyc;
    expect_ev(c + LAT, K_PRESS, 0);
    step(LAT - 1);
    chk("t5_level_before_repress", key_level, 32'd0);
    step(1);
    chk("t5_level_repress", key_level, 32'h1);
    step(4);
    c = cyc;
    key_in[0] = 1'b1;
    expect_ev(c + LAT, K_REL, 0);
    step(LAT + 3);

    // Test 6: key 1 held 100 cycles past key_long (auto-repeat when enabled).
    c = cyc;
    key_in[1] = 1'b0;
    expect_ev(c + LAT, K_PRESS, 1);
    expect_ev(c + LAT + LONG - 1, K_LONG, 1);
`ifdef KEY_REPEAT_EN
    for (int k = 1; k <= 6; k++) expect_ev(c + LAT + LONG - 1 + k * REP, K_REP, 1);
`endif
    step(LAT + LONG - 1 + 50);
    chk("t6_repeat_level_mid_hold", key_repeat, 32'd0);
    step(50);
    chk("t6_level_held", key_level, 32'h2);
    c = cyc;
    key_in[1] = 1'b1;
    expect_ev(c + LAT, K_REL, 1);
    step(LAT + 10);
    chk("t6_level_released", key_level, 32'd0);

    step(10);
    foreach (exp_q[j]) begin
      n_tests++;
      n_fail++;
      $display("FAIL missing_%s ch%0d: not seen, expected at cycle %0d",
               kname[exp_q[j].kind], exp_q[j].ch, exp_q[j].cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
